// File: rtl/rr_resource_arbiter.sv
// rr_resource_arbiter: four-way round-robin arbiter with done handshake and hold-time limit
module rr_resource_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic       busy,
  output logic [1:0] last_id,
  output logic       timeout
);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t     state;
  logic [1:0] ptr;
  logic [1:0] pick;
  logic [7:0] cnt;
  logic       hold_end;
  always_comb begin
    pick = ptr;
    for (int k = 3; k >= 0; k--)
      if (req[ptr + 2'(k)]) pick = ptr + 2'(k);
  end
  assign hold_end = cnt == 8'(MAX_HOLD - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gnt     <= '0;
      busy    <= 1'b0;
      last_id <= '0;
      timeout <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          state   <= GRANT;
          gnt     <= 4'b0001 << pick;
          busy    <= 1'b1;
          last_id <= pick;
          cnt     <= '0;
        end
        GRANT: begin
          cnt <= cnt + 8'd1;
          if (done || !req[last_id] || hold_end) begin
            state   <= RELEASE;
            gnt     <= '0;
            busy    <= 1'b0;
            timeout <= !done && req[last_id];
            ptr     <= last_id + 2'd1;
          end
        end
        default: begin
          state   <= IDLE;
          timeout <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rr_resource_arbiter.sv
// tb_rr_resource_arbiter: directed scenarios for the round-robin arbiter
module tb_rr_resource_arbiter;
  logic       clk = 0;
  logic       reset = 1;
  logic [3:0] req = '0;
  logic       done = 0;
  logic [3:0] gnt;
  logic       busy;
  logic [1:0] last_id;
  logic       timeout;
  int checks = 0;
  int errors = 0;

  rr_resource_arbiter #(.MAX_HOLD(8)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .gnt(gnt), .busy(busy), .last_id(last_id), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; req = 4'b1111; done = 0;
    tick(); tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout); end
    checks++; if (last_id !== 2'd0) begin errors++; $display("FAIL reset_last_id got %0d exp 0", last_id); end
    reset = 0;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt got %b exp 0001", gnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_first_busy got %b exp 1", busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    reset = 1; req = 4'b1111; done = 0;
    tick();
    reset = 0;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        checks++; if (gnt !== exp_g[g]) begin errors++; $display("FAIL rr_gnt grant %0d cycle %0d got %b exp %b", g, c, gnt, exp_g[g]); end
      end
      checks++; if (last_id !== exp_id[g]) begin errors++; $display("FAIL rr_last_id grant %0d got %0d exp %0d", g, last_id, exp_id[g]); end
      done = 1;
      tick();
      done = 0;
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rr_release_gnt grant %0d got %b exp 0000", g, gnt); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rr_release_timeout grant %0d got %b exp 0", g, timeout); end
      tick();
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rr_idle_gnt grant %0d got %b exp 0000", g, gnt); end
    end
  endtask

  task automatic test_timeout();
    reset = 1; req = 4'b0100; done = 0;
    tick();
    reset = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL to_gnt cycle %0d got %b exp 0100", c, gnt); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_early_timeout cycle %0d got %b exp 0", c, timeout); end
    end
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL to_release_gnt got %b exp 0000", gnt); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse got %b exp 1", timeout); end
    tick();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_end got %b exp 0", timeout); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL to_idle_gnt got %b exp 0000", gnt); end
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL to_regrant got %b exp 0100", gnt); end
  endtask

  task automatic test_simultaneous();
    for (int c = 1; c < 8; c++) tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL sim_gnt_last got %b exp 0100", gnt); end
    done = 1;
    tick();
    done = 0;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL sim_done_gnt got %b exp 0000", gnt); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL sim_done_timeout got %b exp 0", timeout); end
    tick(); tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL sim_regrant got %b exp 0100", gnt); end
    tick();
    req = 4'b0000;
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL sim_withdraw_gnt got %b exp 0000", gnt); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL sim_withdraw_timeout got %b exp 0", timeout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sim_withdraw_busy got %b exp 0", busy); end
  endtask

  task automatic test_wrap_skip();
    reset = 1; req = 4'b1000; done = 0;
    tick();
    reset = 0;
    tick();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_first got %b exp 1000", gnt); end
    checks++; if (last_id !== 2'd3) begin errors++; $display("FAIL wrap_last_id3 got %0d exp 3", last_id); end
    req = 4'b0110;
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL wrap_release got %b exp 0000", gnt); end
    tick(); tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL wrap_skip_gnt got %b exp 0010", gnt); end
    checks++; if (last_id !== 2'd1) begin errors++; $display("FAIL wrap_skip_last_id got %0d exp 1", last_id); end
    done = 1;
    tick();
    done = 0;
    tick(); tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL wrap_next got %b exp 0100", gnt); end
  endtask

  task automatic test_reset_mid();
    req = 4'b0100;
    tick(); tick(); tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL mid_pre_gnt got %b exp 0100", gnt); end
    reset = 1;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mid_async_gnt got %b exp 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_async_busy got %b exp 0", busy); end
    req = 4'b0101;
    tick();
    reset = 0;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_after_gnt got %b exp 0001", gnt); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_timeout();
    test_simultaneous();
    test_wrap_skip();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_resource_arbiter.md
# rr_resource_arbiter

Four-requester round-robin arbiter that shares one sequential resource, such as a pattern-detector FSM or a shared datapath unit, between independent requesters. It grants exclusive access to one requester at a time using a request/grant/done handshake. A hold-time limit prevents any requester from keeping the resource indefinitely. The block sits between the requesting clients and the shared resource, and its one-hot grant drives the resource's input mux.

## Interface
- MAX_HOLD, 8: maximum grant duration in cycles; legal range 2..255.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clock clk.
- req  input  4  request lines; req[i] high means requester i wants the resource.
- done  input  1  the currently granted requester finished; sampled only in GRANT.
- gnt  output  4  one-hot registered grant; all zero when no grant.
- busy  output  1  high while in GRANT.
- last_id  output  2  index of the most recently granted requester.
- timeout  output  1  one-cycle pulse when a grant ended by reaching MAX_HOLD.

## Operation
- Three states: IDLE, GRANT, RELEASE. Reset state is IDLE.
- Reset values:
  - state = IDLE, gnt = 0, busy = 0, last_id = 0, timeout = 0.
  - Priority pointer ptr = 0; hold counter cnt = 0.
- IDLE:
  - If req is zero, stay in IDLE.
  - Otherwise select the first asserted req[i], searching i = ptr, ptr+1, ... with wrap-around modulo 4.
  - Go to GRANT with gnt = one-hot(i), last_id = i, cnt = 0.
- GRANT:
  - cnt increments every cycle it is in GRANT.
  - Exit to RELEASE when any of the following holds:
    - done = 1 (normal release);
    - req[last_id] = 0 (requester withdrew);
    - cnt = MAX_HOLD-1 (timeout release).
  - Priority among exit causes: done, then withdrawal, then timeout.
  - timeout is asserted only if neither done nor withdrawal is present in the exiting cycle.
- RELEASE:
  - gnt = 0 and busy = 0.
  - ptr = (last_id + 1) mod 4.
  - timeout is high for exactly this one cycle if the exit was a timeout; otherwise low.
  - Next state is always IDLE.
- Fairness: after requester i is served, requester i has the lowest priority at the next arbitration.
- Under continuous requests from all four, service order is 0,1,2,3,0,...
- done asserted outside GRANT is ignored.
- req changes during GRANT for requesters other than last_id have no effect until the next IDLE.
- cnt width is 8 bits and never wraps, because exit is forced at MAX_HOLD-1.
- All outputs come directly from registers; there is no combinational input-to-output path.

## Timing
- req asserted before rising edge t while in IDLE: gnt is valid after edge t (1-cycle latency).
- Grant length in cycles = number of GRANT cycles, from 1 up to MAX_HOLD.
- done sampled high at edge t while in GRANT: gnt drops after edge t.
- Minimum spacing between consecutive grants is two non-granted cycles (RELEASE then IDLE). gnt never switches directly from one requester to another.
- Asynchronous reset mid-grant: gnt, busy and timeout clear immediately, and ptr returns to 0. The first grant after reset deasserts follows the IDLE rules.

## Test plan
- Reset behaviour:
  - Stimulus: reset high with req = 4'b1111.
  - Required: gnt = 0, busy = 0, timeout = 0.
  - After release, first grant is gnt = 4'b0001 one cycle later.
- Round-robin fairness:
  - Stimulus: req = 4'b1111 held; done pulsed on the 3rd GRANT cycle of each grant.
  - Required: grants 0001, 0010, 0100, 1000, 0001.
  - Required: each grant lasts 3 cycles, separated by 2 zero cycles.
- Timeout:
  - Stimulus: MAX_HOLD = 8, req = 4'b0100, done never asserted.
  - Required: gnt = 0100 for exactly 8 cycles, then timeout high for 1 cycle, then regrant to 0100 after IDLE.
- Simultaneous events:
  - Stimulus: done high in the same cycle cnt reaches 7 (MAX_HOLD = 8).
  - Required: normal release with timeout = 0.
  - Stimulus: req[last_id] drops in a cycle with done low.
  - Required: release next edge, timeout = 0.
- Wrap-around and skip:
  - Stimulus: last_id = 3, then req = 4'b0110.
  - Required: gnt = 0010, last_id = 1; next arbitration grants 0100.
- Reset mid-operation:
  - Stimulus: assert reset on the 4th cycle of a grant to requester 2.
  - Required: gnt = 0 immediately; after release with req = 4'b0101, grant goes to 0001 (ptr = 0).
